// File: rtl/uart_rx_fifo_writer_pkg.sv
// Shared types and constants for the UART receive path feeding the byte FIFO.
package uart_rx_pkg;

    localparam int DATA_BITS = 8;
    localparam int BYTE_W    = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } rx_state_e;

    // Even parity: the parity bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [BYTE_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_writer_if.sv
// FIFO write-port bundle between the UART receiver (master) and the byte FIFO (slave).
interface uart_rx_fifo_writer_if import uart_rx_pkg::*; ();

    logic              wr_en;
    logic [BYTE_W-1:0] din;
    logic              fifo_full;

    modport master (output wr_en, output din, input fifo_full);
    modport slave  (input wr_en, input din, output fifo_full);

endinterface

// File: rtl/uart_rx_fifo_writer_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line; resets to the idle (high) level.
module rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_r <= 1'b1;
            sync_r <= 1'b1;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/uart_rx_fifo_writer.sv
// 8N1 UART receiver that pushes good bytes into a FIFO and keeps sticky error flags.
// Optional even-parity frame (8E1) enabled by defining UART_RX_PARITY_EN.
module uart_rx_fifo_writer import uart_rx_pkg::*; #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_in,
    input  logic                  clr_err,
    uart_rx_fifo_writer_if.master fifo,
    output logic                  busy,
    output logic                  frame_err,
    output logic                  overrun,
    output logic                  parity_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    logic              rx_s;
    rx_state_e         state_r, state_n;
    logic [CNT_W-1:0]  cnt_r, cnt_n;
    logic [BIT_W-1:0]  bit_r, bit_n;
    logic [BYTE_W-1:0] shift_r, shift_n;
    logic [BYTE_W-1:0] din_r;
    logic              wr_en_r;
    logic              frame_r, over_r;
    logic              push_s, frame_set_s, over_set_s;
`ifdef UART_RX_PARITY_EN
    logic              par_bit_r, par_bit_n;
    logic              par_r;
    logic              par_set_s;
`endif

    rx_sync u_rx_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx_in),
        .q     (rx_s)
    );

    // Next-state, bit timing and push/drop decisions.
    always_comb begin
        state_n     = state_r;
        cnt_n       = cnt_r + CNT_W'(1);
        bit_n       = bit_r;
        shift_n     = shift_r;
        push_s      = 1'b0;
        frame_set_s = 1'b0;
        over_set_s  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_n   = par_bit_r;
        par_set_s   = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                cnt_n = {CNT_W{1'b0}};
                if (!rx_s) state_n = START;
                else       state_n = IDLE;
            end
            START: begin
                if (cnt_r == CNT_MID) begin
                    cnt_n = {CNT_W{1'b0}};
                    bit_n = {BIT_W{1'b0}};
                    if (!rx_s) state_n = DATA;
                    else       state_n = IDLE;
                end else begin
                    state_n = START;
                end
            end
            DATA: begin
                if (cnt_r == CNT_LAST) begin
                    cnt_n   = {CNT_W{1'b0}};
                    shift_n = {rx_s, shift_r[BYTE_W-1:1]};
                    bit_n   = bit_r + BIT_W'(1);
`ifdef UART_RX_PARITY_EN
                    if (bit_r == BIT_LAST) state_n = PARITY;
                    else                   state_n = DATA;
`else
                    if (bit_r == BIT_LAST) state_n = STOP;
                    else                   state_n = DATA;
`endif
                end else begin
                    state_n = DATA;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_r == CNT_LAST) begin
                    cnt_n     = {CNT_W{1'b0}};
                    par_bit_n = rx_s;
                    state_n   = STOP;
                end else begin
                    state_n = PARITY;
                end
            end
`endif
            STOP: begin
                if (cnt_r == CNT_LAST) begin
                    cnt_n = {CNT_W{1'b0}};
                    if (!rx_s) begin
                        frame_set_s = 1'b1;
                        state_n     = WAIT_HIGH;
`ifdef UART_RX_PARITY_EN
                    end else if (even_parity(shift_r) != par_bit_r) begin
                        par_set_s = 1'b1;
                        state_n   = IDLE;
`endif
                    end else if (fifo.fifo_full) begin
                        over_set_s = 1'b1;
                        state_n    = IDLE;
                    end else begin
                        push_s  = 1'b1;
                        state_n = IDLE;
                    end
                end else begin
                    state_n = STOP;
                end
            end
            WAIT_HIGH: begin
                cnt_n = {CNT_W{1'b0}};
                if (rx_s) state_n = IDLE;
                else      state_n = WAIT_HIGH;
            end
            default: begin
                cnt_n   = {CNT_W{1'b0}};
                state_n = IDLE;
            end
        endcase
    end

    // State, datapath and registered FIFO write port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            bit_r   <= {BIT_W{1'b0}};
            shift_r <= {BYTE_W{1'b0}};
            wr_en_r <= 1'b0;
            din_r   <= {BYTE_W{1'b0}};
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
            bit_r   <= bit_n;
            shift_r <= shift_n;
            wr_en_r <= push_s;
            if (push_s) din_r <= shift_r;
            else        din_r <= din_r;
        end
    end

    // Sticky error flags; a new error in the clearing cycle wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_r <= 1'b0;
            over_r  <= 1'b0;
        end else begin
            if (frame_set_s)  frame_r <= 1'b1;
            else if (clr_err) frame_r <= 1'b0;
            else              frame_r <= frame_r;
            if (over_set_s)   over_r  <= 1'b1;
            else if (clr_err) over_r  <= 1'b0;
            else              over_r  <= over_r;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Received parity bit and its sticky mismatch flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            par_bit_r <= 1'b0;
            par_r     <= 1'b0;
        end else begin
            par_bit_r <= par_bit_n;
            if (par_set_s)    par_r <= 1'b1;
            else if (clr_err) par_r <= 1'b0;
            else              par_r <= par_r;
        end
    end
    assign parity_err = par_r;
`else
    assign parity_err = 1'b0;
`endif

    assign fifo.wr_en = wr_en_r;
    assign fifo.din   = din_r;
    assign busy       = (state_r != IDLE);
    assign frame_err  = frame_r;
    assign overrun    = over_r;

endmodule

// File: tb/tb_uart_rx_fifo_writer.sv
// Self-checking bench for uart_rx_fifo_writer with a frame-level reference model.
module tb_uart_rx_fifo_writer;

    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = 2 + CPB / 2 + 10 * CPB + 1;
`else
    localparam int LAT = 2 + CPB / 2 + 9 * CPB + 1;
`endif

    logic clk = 1'b0;
    logic reset;
    logic rx_in;
    logic clr_err;
    logic busy, frame_err, overrun, parity_err;

    uart_rx_fifo_writer_if ifc ();

    uart_rx_fifo_writer #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_in      (rx_in),
        .clr_err    (clr_err),
        .fifo       (ifc),
        .busy       (busy),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int b2b_viol = 0;
    logic prev_wr = 1'b0;
    logic [7:0] got_q[$];
    int got_t[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Collect every FIFO write away from the active edge.
    always @(negedge clk) begin
        if (ifc.wr_en === 1'b1) begin
            got_q.push_back(ifc.din);
            got_t.push_back(cyc);
            if (prev_wr === 1'b1) b2b_viol = b2b_viol + 1;
        end
        prev_wr = ifc.wr_en;
    end

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Called on a negedge; returns on the negedge ending the stop bit, line left at stop level.
    task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic par_flip,
                              output int t0);
        rx_in = 1'b0;
        t0 = cyc;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_in = b[i];
            repeat (CPB) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rx_in = (^b) ^ par_flip;
        repeat (CPB) @(negedge clk);
`else
        if (par_flip) rx_in = 1'b1;
`endif
        rx_in = stop_v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; rx_in = 1'b1; clr_err = 1'b0; ifc.fifo_full = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (ifc.wr_en !== 1'b0) begin n_bad++; $display("FAIL reset_wr_en got=%b exp=0", ifc.wr_en); end
        n_cmp++; if (ifc.din !== 8'h00) begin n_bad++; $display("FAIL reset_din got=%h exp=00", ifc.din); end
        n_cmp++; if ({busy, frame_err, overrun, parity_err} !== 4'b0000) begin
            n_bad++; $display("FAIL reset_status got=%b exp=0000", {busy, frame_err, overrun, parity_err}); end
        reset = 1'b1;
        idle(4);
    endtask

    task automatic test_single();
        int t0;
        got_q.delete(); got_t.delete();
        send_frame(8'hA5, 1'b1, 1'b0, t0);
        idle(4);
        n_cmp++; if (got_q.size() !== 1) begin n_bad++; $display("FAIL single_count got=%0d exp=1", got_q.size()); end
        if (got_q.size() > 0) begin
            n_cmp++; if (got_q[0] !== 8'hA5) begin n_bad++; $display("FAIL single_din got=%h exp=a5", got_q[0]); end
            n_cmp++; if ((got_t[0] - t0) < LAT - 1 || (got_t[0] - t0) > LAT + 1) begin
                n_bad++; $display("FAIL single_latency got=%0d exp=%0d+-1", got_t[0] - t0, LAT); end
        end
        n_cmp++; if ({busy, frame_err, overrun, parity_err} !== 4'b0000) begin
            n_bad++; $display("FAIL single_status got=%b exp=0000", {busy, frame_err, overrun, parity_err}); end
    endtask

    task automatic test_frame_err();
        int t0;
        got_q.delete(); got_t.delete();
        send_frame(8'h3C, 1'b0, 1'b0, t0);
        repeat (40) @(negedge clk);
        n_cmp++; if (got_q.size() !== 0) begin n_bad++; $display("FAIL ferr_nopush got=%0d exp=0", got_q.size()); end
        n_cmp++; if (frame_err !== 1'b1) begin n_bad++; $display("FAIL ferr_flag got=%b exp=1", frame_err); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL ferr_busy_low_line got=%b exp=1", busy); end
        idle(5);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ferr_busy_released got=%b exp=0", busy); end
        pulse_clr();
        n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL ferr_clear got=%b exp=0", frame_err); end
    endtask

    task automatic test_overrun();
        int t0;
        got_q.delete(); got_t.delete();
        ifc.fifo_full = 1'b1;
        send_frame(8'h55, 1'b1, 1'b0, t0);
        idle(4);
        ifc.fifo_full = 1'b0;
        n_cmp++; if (got_q.size() !== 0) begin n_bad++; $display("FAIL ovr_nopush got=%0d exp=0", got_q.size()); end
        n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_flag got=%b exp=1", overrun); end
        send_frame(8'h0F, 1'b1, 1'b0, t0);
        idle(4);
        n_cmp++; if (got_q.size() !== 1) begin n_bad++; $display("FAIL ovr_next_count got=%0d exp=1", got_q.size()); end
        if (got_q.size() > 0) begin
            n_cmp++; if (got_q[0] !== 8'h0F) begin n_bad++; $display("FAIL ovr_next_din got=%h exp=0f", got_q[0]); end
        end
        n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_sticky got=%b exp=1", overrun); end
        pulse_clr();
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL ovr_clear got=%b exp=0", overrun); end
    endtask

    task automatic test_glitch();
        got_q.delete(); got_t.delete();
        rx_in = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL glitch_busy_start got=%b exp=1", busy); end
        idle(30);
        n_cmp++; if (got_q.size() !== 0) begin n_bad++; $display("FAIL glitch_nopush got=%0d exp=0", got_q.size()); end
        n_cmp++; if ({busy, frame_err, overrun, parity_err} !== 4'b0000) begin
            n_bad++; $display("FAIL glitch_status got=%b exp=0000", {busy, frame_err, overrun, parity_err}); end
    endtask

    task automatic test_reset_midframe();
        int t0;
        logic [7:0] b;
        b = 8'h81;
        got_q.delete(); got_t.delete();
        rx_in = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx_in = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx_in = b[3];
        repeat (CPB / 2) @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++; if ({ifc.wr_en, busy} !== 2'b00) begin
            n_bad++; $display("FAIL rst_mid_abort got=%b exp=00", {ifc.wr_en, busy}); end
        @(negedge clk);
        rx_in = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        idle(4);
        n_cmp++; if (got_q.size() !== 0) begin n_bad++; $display("FAIL rst_mid_nopush got=%0d exp=0", got_q.size()); end
        send_frame(8'hFF, 1'b1, 1'b0, t0);
        idle(4);
        n_cmp++; if (got_q.size() !== 1) begin n_bad++; $display("FAIL rst_after_count got=%0d exp=1", got_q.size()); end
        if (got_q.size() > 0) begin
            n_cmp++; if (got_q[0] !== 8'hFF) begin n_bad++; $display("FAIL rst_after_din got=%h exp=ff", got_q[0]); end
        end
    endtask

    task automatic test_back_to_back();
        int t0;
        int model_cnt;
        got_q.delete(); got_t.delete();
        b2b_viol = 0;
        model_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            send_frame(8'(i), 1'b1, 1'b0, t0);
            model_cnt++;
        end
        idle(4);
        n_cmp++; if (got_q.size() !== 16) begin n_bad++; $display("FAIL b2b_count got=%0d exp=16", got_q.size()); end
        for (int i = 0; i < 16; i++) begin
            if (i < got_q.size()) begin
                n_cmp++; if (got_q[i] !== 8'(i)) begin n_bad++; $display("FAIL b2b_order[%0d] got=%h exp=%h", i, got_q[i], 8'(i)); end
            end
        end
        n_cmp++; if (b2b_viol !== 0) begin n_bad++; $display("FAIL b2b_adjacent_wr got=%0d exp=0", b2b_viol); end
        ifc.fifo_full = (model_cnt >= 16);
        send_frame(8'h10, 1'b1, 1'b0, t0);
        idle(4);
        n_cmp++; if (got_q.size() !== 16) begin n_bad++; $display("FAIL b2b_full_nopush got=%0d exp=16", got_q.size()); end
        n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL b2b_full_overrun got=%b exp=1", overrun); end
        ifc.fifo_full = 1'b0;
        pulse_clr();
`ifdef UART_RX_PARITY_EN
        send_frame(8'h96, 1'b1, 1'b1, t0);
        idle(4);
        n_cmp++; if (parity_err !== 1'b1) begin n_bad++; $display("FAIL par_flag got=%b exp=1", parity_err); end
        n_cmp++; if (got_q.size() !== 16) begin n_bad++; $display("FAIL par_nopush got=%0d exp=16", got_q.size()); end
        pulse_clr();
`endif
    endtask

    task automatic test_random();
        int t0;
        logic [7:0] b;
        logic stop_v, full_v, pflip;
        logic exp_fe, exp_ov, exp_pe;
        logic [7:0] exp_q[$];
        got_q.delete(); got_t.delete();
        exp_fe = 1'b0; exp_ov = 1'b0; exp_pe = 1'b0;
        for (int n = 0; n < 14; n++) begin
            b      = 8'($urandom_range(0, 255));
            stop_v = ($urandom_range(0, 3) != 0);
            full_v = ($urandom_range(0, 3) == 0);
`ifdef UART_RX_PARITY_EN
            pflip  = ($urandom_range(0, 4) == 0);
`else
            pflip  = 1'b0;
`endif
            ifc.fifo_full = full_v;
            send_frame(b, stop_v, pflip, t0);
            if (!stop_v)     exp_fe = 1'b1;
            else if (pflip)  exp_pe = 1'b1;
            else if (full_v) exp_ov = 1'b1;
            else             exp_q.push_back(b);
            ifc.fifo_full = 1'b0;
            idle(CPB + $urandom_range(0, 20));
        end
        n_cmp++; if (got_q.size() !== exp_q.size()) begin
            n_bad++; $display("FAIL rand_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) begin
                n_cmp++; if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL rand_byte[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
            end
        end
        n_cmp++; if ({frame_err, overrun, parity_err} !== {exp_fe, exp_ov, exp_pe}) begin
            n_bad++; $display("FAIL rand_flags got=%b exp=%b", {frame_err, overrun, parity_err}, {exp_fe, exp_ov, exp_pe}); end
        pulse_clr();
        n_cmp++; if ({frame_err, overrun, parity_err} !== 3'b000) begin
            n_bad++; $display("FAIL rand_clear got=%b exp=000", {frame_err, overrun, parity_err}); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_frame_err();
        test_overrun();
        test_glitch();
        test_reset_midframe();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo_writer.md
Name: uart_rx_fifo_writer

Overview:
- UART receiver stage directly upstream of the 16x8 byte FIFO.
- Deserialises an asynchronous 8N1 serial line and pushes each good byte into the FIFO through its wr_en/din write port.
- Drops bytes and raises sticky status flags on framing errors and on FIFO-full overruns.
- Single clock domain; the rx line is asynchronous and is synchronised internally.

Parameters:
- CLKS_PER_BIT, 434: clock cycles per serial bit (50 MHz / 115200). Legal minimum is 4.
- CNT_W, $clog2(CLKS_PER_BIT): width of the bit-timing counter. Derived; not overridden.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- rx_in  in  1  serial input, idle high, asynchronous to clk.
- fifo_full  in  1  FIFO full flag.
- clr_err  in  1  one-cycle pulse that clears the sticky error flags.
- wr_en  out  1  FIFO write strobe, one-cycle pulse.
- din  out  8  byte to the FIFO; registered, held stable between pushes.
- busy  out  1  high whenever the state machine is not IDLE.
- frame_err  out  1  sticky: a stop bit was sampled 0.
- overrun  out  1  sticky: a good byte was dropped because fifo_full=1.
- parity_err  out  1  sticky: parity mismatch. Tied 0 when the optional feature is off.

Behaviour:
- Reset (reset=0, asynchronous):
  - wr_en=0, din=8'h00, busy=0, all error flags 0.
  - State IDLE, counters 0.
  - Synchroniser flops reset to 1 (line idle).
- rx_in passes through a 2-FF synchroniser; the FSM uses rx_s only.
- IDLE: if rx_s=0, go to START and clear the counter.
- START:
  - At count CLKS_PER_BIT/2-1 (mid start bit), sample rx_s.
  - rx_s=0: go to DATA with counter and bit index cleared.
  - rx_s=1: glitch; return to IDLE with no flag.
- DATA:
  - Every CLKS_PER_BIT cycles, sample rx_s into a shift register, LSB first.
  - After bit index 7, go to STOP (or PARITY when enabled).
- STOP: after CLKS_PER_BIT cycles, sample rx_s.
  - rx_s=1, fifo_full=0: on the next edge, load din with the byte and pulse wr_en=1 for exactly one cycle; go to IDLE.
  - rx_s=1, fifo_full=1: set overrun, no wr_en, byte discarded; go to IDLE.
  - rx_s=0: set frame_err, no wr_en; go to WAIT_HIGH.
- WAIT_HIGH: stay until rx_s=1, then go to IDLE. This handles line breaks.
- fifo_full is sampled only in the cycle the push decision is made.
- Push timing: wr_en asserts 2 (synchroniser) + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles after the falling edge on rx_in, with ±1 cycle tolerance.
- At most one wr_en per frame. wr_en is never asserted on the cycle after a push.
- Error flags:
  - clr_err clears frame_err, overrun and parity_err.
  - If an error sets in the same cycle as clr_err, set wins.
- Reset asserted mid-frame: immediate abort, partial byte lost, no wr_en.
- Back-to-back frames: a start bit arriving immediately after the stop-bit sample must be caught. IDLE is entered on the same edge as the push.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - PARITY state between DATA and STOP samples one even-parity bit.
  - On mismatch, set parity_err at the stop-bit sample and drop the byte.
  - Frame length becomes 11 bits; push latency grows by CLKS_PER_BIT.
- Undefined:
  - No PARITY state; parity_err is held at 0.
  - Frame is 8N1.

Decomposition:
- Package uart_rx_pkg holds:
  - state enum typedef: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - DATA_BITS=8.
  - BYTE_W=8.
- Sub-module rx_sync: 2-flop synchroniser with asynchronous active-low reset, reset value 1.

Test Plan (CLKS_PER_BIT=16):
- 1. Send 0xA5 (8N1), fifo_full=0 -> single wr_en pulse with din=8'hA5 inside the latency window; all flags 0; busy returns to 0.
- 2. Send 0x3C with stop bit 0, then hold rx low 40 cycles -> no wr_en; frame_err=1; busy stays high until rx returns high. Then clr_err pulse -> frame_err=0.
- 3. fifo_full=1 during 0x55 -> no wr_en, overrun=1. Drop fifo_full, send 0x0F -> wr_en with din=8'h0F; overrun stays 1 until clr_err.
- 4. rx_in low for 4 cycles only -> START aborts at mid-bit; no wr_en, no flags, busy back to 0.
- 5. Assert reset=0 during DATA bit 3 of 0x81 -> wr_en=0, busy=0 within the same cycle. Release reset, send 0xFF -> din=8'hFF pushed.
- 6. Stream 16 back-to-back frames 0x00..0x0F into the FIFO -> 16 pushes in order; FIFO reports full. With UART_RX_PARITY_EN, a frame with wrong parity -> parity_err=1, no push.
